// File: rtl/exec_unit_mc_if.sv
// Handshake/operand bundle between decode, the execute unit and memory.
// The unit sits on the slave side; the producer/consumer pair is the master.
interface exec_unit_mc_if #(
    parameter int WIDTH = 16
);
    logic             inp_valid;
    logic             out_ready;
    logic             inp_aluSrc;
    logic [2:0]       inp_aluOp;
    logic [3:0]       inp_func;
    logic [WIDTH-1:0] inp_data1;
    logic [WIDTH-1:0] inp_data2;
    logic [WIDTH-1:0] inp_immidate;
    logic             out_valid;
    logic             inp_ready;
    logic [WIDTH-1:0] out_aluResult;
    logic             out_zero;
    logic             out_busy;

    modport master (
        output inp_valid, inp_aluSrc, inp_aluOp, inp_func,
        output inp_data1, inp_data2, inp_immidate, inp_ready,
        input  out_ready, out_valid, out_aluResult, out_zero, out_busy
    );

    modport slave (
        input  inp_valid, inp_aluSrc, inp_aluOp, inp_func,
        input  inp_data1, inp_data2, inp_immidate, inp_ready,
        output out_ready, out_valid, out_aluResult, out_zero, out_busy
    );
endinterface

// File: rtl/exec_unit_mc.sv
// Execute stage: single-cycle ALU ops plus a WIDTH-cycle shift-add multiply,
// with a registered result toward memory under valid/ready flow control.
module exec_unit_mc #(
    parameter int WIDTH = 16,
    parameter int SHW   = $clog2(WIDTH)
) (
    input logic         inp_clk,
    input logic         inp_resetN,
    exec_unit_mc_if.slave bus
);
    localparam int CW = $clog2(WIDTH) + 1;

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_AND = 4'd2;
    localparam logic [3:0] OP_OR  = 4'd3;
    localparam logic [3:0] OP_XOR = 4'd4;
    localparam logic [3:0] OP_NOR = 4'd5;
    localparam logic [3:0] OP_SLT = 4'd6;
    localparam logic [3:0] OP_SLL = 4'd7;
    localparam logic [3:0] OP_SRL = 4'd8;
    localparam logic [3:0] OP_SRA = 4'd9;
    localparam logic [3:0] OP_MUL = 4'd10;

    typedef enum logic {
        S_IDLE,
        S_MUL
    } state_e;

    state_e           state_q;
    logic [WIDTH-1:0] a_q, b_q, acc_q;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] res_q;
    logic             zero_q, valid_q, busy_q;

    logic [3:0]       ctl;
    logic [WIDTH-1:0] opa, opb, alu_res, mul_sum;
    logic [SHW-1:0]   shamt;
    logic             ready, accept;

    assign opa   = bus.inp_data1;
    assign opb   = bus.inp_aluSrc ? bus.inp_immidate : bus.inp_data2;
    assign shamt = opb[SHW-1:0];

    always_comb begin
        ctl = OP_ADD;
        case (bus.inp_aluOp)
            3'b001:  ctl = OP_SUB;
            3'b010:  ctl = bus.inp_func;
            3'b011:  ctl = OP_AND;
            3'b100:  ctl = OP_OR;
            3'b101:  ctl = OP_SLT;
            default: ctl = OP_ADD;
        endcase
    end

    // MUL and the reserved codes produce 0 here; MUL goes through the FSM
    always_comb begin
        alu_res = '0;
        case (ctl)
            OP_ADD:  alu_res = opa + opb;
            OP_SUB:  alu_res = opa - opb;
            OP_AND:  alu_res = opa & opb;
            OP_OR:   alu_res = opa | opb;
            OP_XOR:  alu_res = opa ^ opb;
            OP_NOR:  alu_res = ~(opa | opb);
            OP_SLT:  alu_res = {{(WIDTH-1){1'b0}},
                                $signed(opa) < $signed(opb)};
            OP_SLL:  alu_res = opa << shamt;
            OP_SRL:  alu_res = opa >> shamt;
            OP_SRA:  alu_res = $unsigned($signed(opa) >>> shamt);
            default: alu_res = '0;
        endcase
    end

    assign mul_sum = acc_q + (b_q[0] ? a_q : '0);

    assign ready  = (state_q == S_IDLE) && (!valid_q || bus.inp_ready);
    assign accept = bus.inp_valid && ready;

    always_ff @(posedge inp_clk or negedge inp_resetN) begin
        if (!inp_resetN) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            res_q   <= '0;
            zero_q  <= 1'b0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (accept && ctl == OP_MUL) begin
                        a_q     <= opa;
                        b_q     <= opb;
                        acc_q   <= '0;
                        cnt_q   <= CW'(WIDTH);
                        valid_q <= 1'b0;
                        busy_q  <= 1'b1;
                        state_q <= S_MUL;
                    end else if (accept) begin
                        res_q   <= alu_res;
                        zero_q  <= (alu_res == '0);
                        valid_q <= 1'b1;
                    end else if (bus.inp_ready) begin
                        valid_q <= 1'b0;
                    end
                end
                S_MUL: begin
                    acc_q <= mul_sum;
                    a_q   <= a_q << 1;
                    b_q   <= b_q >> 1;
                    cnt_q <= cnt_q - 1'b1;
                    if (cnt_q == CW'(1)) begin
                        res_q   <= mul_sum;
                        zero_q  <= (mul_sum == '0);
                        valid_q <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bus.out_ready     = ready;
    assign bus.out_valid     = valid_q;
    assign bus.out_aluResult = res_q;
    assign bus.out_zero      = zero_q;
    assign bus.out_busy      = busy_q;
endmodule

// File: tb/tb_exec_unit_mc.sv
// Directed bench for exec_unit_mc: vector table for single-cycle ops,
// hand sequences for multiply, back-pressure and reset mid-multiply.
module tb_exec_unit_mc;
    localparam int W = 16;

    logic clk;
    logic rst_n;

    exec_unit_mc_if #(.WIDTH(W)) bus ();

    exec_unit_mc #(.WIDTH(W)) dut (
        .inp_clk    (clk),
        .inp_resetN (rst_n),
        .bus        (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic         src;
        logic [2:0]   aop;
        logic [3:0]   fn;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] imm;
        logic [W-1:0] exp_res;
        logic         exp_z;
    } vec_t;

    vec_t vt[16];
    int   n_pass;
    int   n_total;

    task automatic check(input string name, input logic [W-1:0] got,
                         input logic [W-1:0] exp);
        n_total++;
        if (got !== exp)
            $display("FAIL %s: got %h expected %h", name, got, exp);
        else
            n_pass++;
    endtask

    task automatic drive(input logic src, input logic [2:0] aop,
                         input logic [3:0] fn, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic [W-1:0] imm);
        bus.inp_aluSrc   = src;
        bus.inp_aluOp    = aop;
        bus.inp_func     = fn;
        bus.inp_data1    = a;
        bus.inp_data2    = b;
        bus.inp_immidate = imm;
    endtask

    task automatic mul_run(input string name, input logic [W-1:0] a,
                           input logic [W-1:0] b, input logic [W-1:0] exp);
        int n;
        @(negedge clk);
        drive(1'b0, 3'b010, 4'b1010, a, b, '0);
        bus.inp_valid = 1'b1;
        @(posedge clk);
        #1;
        n = 0;
        while (bus.out_busy && n < 40) begin
            n++;
            if (bus.out_ready !== 1'b0 || bus.out_valid !== 1'b0)
                check({name, "_busy_hs"}, {14'd0, bus.out_ready,
                      bus.out_valid}, '0);
            @(posedge clk);
            #1;
        end
        bus.inp_valid = 1'b0;
        check({name, "_busy_cycles"}, W'(n), W'(16));
        check({name, "_valid"}, W'(bus.out_valid), W'(1));
        check({name, "_res"}, bus.out_aluResult, exp);
        @(posedge clk);
        #1;
        check({name, "_no_reaccept"}, W'({bus.out_valid, bus.out_busy}),
              W'(0));
    endtask

    initial begin
        vt[0]  = '{0, 3'b000, 4'h0, 16'h0005, 16'h0003, 16'h0, 16'h0008, 0};
        vt[1]  = '{1, 3'b001, 4'h0, 16'h1234, 16'h0, 16'h1234, 16'h0000, 1};
        vt[2]  = '{0, 3'b010, 4'h6, 16'hFFFF, 16'h0001, 16'h0, 16'h0001, 0};
        vt[3]  = '{0, 3'b010, 4'h9, 16'h8000, 16'h0004, 16'h0, 16'hF800, 0};
        vt[4]  = '{0, 3'b010, 4'h8, 16'h8000, 16'h0004, 16'h0, 16'h0800, 0};
        vt[5]  = '{0, 3'b010, 4'h7, 16'h0001, 16'h0013, 16'h0, 16'h0008, 0};
        vt[6]  = '{0, 3'b011, 4'h0, 16'hF0F0, 16'h0FF0, 16'h0, 16'h00F0, 0};
        vt[7]  = '{0, 3'b100, 4'h0, 16'hF000, 16'h000F, 16'h0, 16'hF00F, 0};
        vt[8]  = '{0, 3'b010, 4'h4, 16'hFFFF, 16'h00FF, 16'h0, 16'hFF00, 0};
        vt[9]  = '{0, 3'b010, 4'h5, 16'hF0F0, 16'h0F0F, 16'h0, 16'h0000, 1};
        vt[10] = '{0, 3'b101, 4'h0, 16'h0001, 16'hFFFF, 16'h0, 16'h0000, 1};
        vt[11] = '{0, 3'b010, 4'hC, 16'h0005, 16'h0003, 16'h0, 16'h0000, 1};
        vt[12] = '{0, 3'b110, 4'h0, 16'h0007, 16'h0009, 16'h0, 16'h0010, 0};
        vt[13] = '{0, 3'b000, 4'h0, 16'hFFFF, 16'h0001, 16'h0, 16'h0000, 1};
        vt[14] = '{0, 3'b010, 4'h1, 16'h0003, 16'h0005, 16'h0, 16'hFFFE, 0};
        vt[15] = '{1, 3'b010, 4'h0, 16'h0010, 16'h0999, 16'h20, 16'h0030, 0};

        n_pass  = 0;
        n_total = 0;
        rst_n   = 1'b0;
        bus.inp_valid = 1'b0;
        bus.inp_ready = 1'b1;
        drive(1'b0, 3'b000, 4'h0, '0, '0, '0);

        repeat (2) @(posedge clk);
        #1;
        check("rst_valid", W'(bus.out_valid), W'(0));
        check("rst_res", bus.out_aluResult, W'(0));
        check("rst_zero_busy", W'({bus.out_zero, bus.out_busy}), W'(0));
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            drive(vt[i].src, vt[i].aop, vt[i].fn, vt[i].a, vt[i].b,
                  vt[i].imm);
            bus.inp_valid = 1'b1;
            @(posedge clk);
            #1;
            bus.inp_valid = 1'b0;
            check($sformatf("vec%0d_valid", i), W'(bus.out_valid), W'(1));
            check($sformatf("vec%0d_res", i), bus.out_aluResult,
                  vt[i].exp_res);
            check($sformatf("vec%0d_zero", i), W'(bus.out_zero),
                  W'(vt[i].exp_z));
        end
        @(posedge clk);
        #1;
        check("drain", W'(bus.out_valid), W'(0));

        mul_run("mul_a", 16'h0012, 16'h0034, 16'h03A8);
        mul_run("mul_b", 16'hFFFF, 16'hFFFF, 16'h0001);

        // back-pressure: hold result while a new op waits upstream
        @(negedge clk);
        drive(1'b0, 3'b000, 4'h0, 16'h0001, 16'h0002, '0);
        bus.inp_valid = 1'b1;
        bus.inp_ready = 1'b0;
        @(posedge clk);
        #1;
        drive(1'b0, 3'b000, 4'h0, 16'h0010, 16'h0020, '0);
        for (int i = 0; i < 5; i++) begin
            check($sformatf("bp%0d_ready", i), W'(bus.out_ready), W'(0));
            check($sformatf("bp%0d_res", i),
                  W'({bus.out_valid, 15'd0}) | bus.out_aluResult,
                  16'h8003);
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        bus.inp_ready = 1'b1;
        #1;
        check("bp_ready_comb", W'(bus.out_ready), W'(1));
        @(posedge clk);
        #1;
        bus.inp_valid = 1'b0;
        check("bp_new_valid", W'(bus.out_valid), W'(1));
        check("bp_new_res", bus.out_aluResult, 16'h0030);
        @(posedge clk);
        #1;

        // reset during multiply
        @(negedge clk);
        drive(1'b0, 3'b010, 4'b1010, 16'h0003, 16'h0005, '0);
        bus.inp_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.inp_valid = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        check("rmul_busy7", W'(bus.out_busy), W'(1));
        rst_n = 1'b0;
        #1;
        check("rmul_busy", W'(bus.out_busy), W'(0));
        check("rmul_out", W'({bus.out_valid, bus.out_zero}) |
              bus.out_aluResult, W'(0));
        @(negedge clk);
        rst_n = 1'b1;
        begin
            int stale;
            stale = 0;
            repeat (20) begin
                @(posedge clk);
                #1;
                if (bus.out_valid || bus.out_busy) stale++;
            end
            check("rmul_no_stale", W'(stale), W'(0));
        end
        @(negedge clk);
        drive(1'b0, 3'b000, 4'h0, 16'h0100, 16'h0023, '0);
        bus.inp_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.inp_valid = 1'b0;
        check("post_add_valid", W'(bus.out_valid), W'(1));
        check("post_add_res", bus.out_aluResult, 16'h0123);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end
endmodule
